// File: rtl/pri_enc_pkg.sv
// Shared definitions for the pipelined priority encoder.
//   clog2_min1 : code width for a given request width, never less than 1 bit
//   DEFAULT_*  : default request width and the matching code width
//   code_t     : code type for the default width
package pri_enc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int clog2_min1(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEFAULT_CODE_W = clog2_min1(DEFAULT_WIDTH);

  typedef logic [DEFAULT_CODE_W-1:0] code_t;

endpackage

// File: rtl/pri_enc_comb.sv
// Combinational find-highest-set encoder.
//   vec : input vector, bit WIDTH-1 has the highest priority
//   idx : index of the highest set bit (0 when vec is all zero)
//   any : 1 when any bit of vec is set
module pri_enc_comb
  import pri_enc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CODE_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan: the last set bit seen (the highest) wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = CODE_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_pipe.sv
// Registered priority encoder with sticky pending requests and a
// valid/ready output stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : requests OR'd into pending every cycle
//   mask        : 1 = pending line eligible for selection
//   flush       : synchronous clear (pending takes req, output stage empties)
//   code_valid  : output stage holds a selected index
//   code        : selected index
//   code_ready  : consumer accepts code on code_valid & code_ready
//   pending     : current pending register
//   z           : no eligible pending request and output stage empty
// Build option: define ROUND_ROBIN_EN for rotating priority; without it the
// highest eligible index always wins.
module priority_encoder_pipe
  import pri_enc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CODE_W = clog2_min1(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req,
  input  logic [WIDTH-1:0]  mask,
  input  logic              flush,
  output logic              code_valid,
  output logic [CODE_W-1:0] code,
  input  logic              code_ready,
  output logic [WIDTH-1:0]  pending,
  output logic              z
);

  logic [WIDTH-1:0]  elig;
  logic [WIDTH-1:0]  search_vec;
  logic [WIDTH-1:0]  load_onehot;
  logic [CODE_W-1:0] found_idx;
  logic [CODE_W-1:0] sel_idx;
  logic              found;
  logic              free;
  logic              do_load;

  // Only registered pending is eligible; same-cycle req waits one edge.
  assign elig    = pending & mask;
  assign free    = !code_valid || code_ready;
  assign do_load = free && found && !flush;
  assign load_onehot = do_load ? (WIDTH'(1) << sel_idx) : '0;
  assign z       = (elig == '0) && !code_valid;

  pri_enc_comb #(.WIDTH(WIDTH)) u_enc (
    .vec (search_vec),
    .idx (found_idx),
    .any (found)
  );

`ifdef ROUND_ROBIN_EN
  // rr_start is the first index searched next: one below the last loaded
  // index. Reset/flush put it at WIDTH-1 so the first arbitration matches
  // fixed priority. Rotating elig right by rr_start+1 moves rr_start to the
  // top bit, where the fixed encoder gives it the highest priority.
  logic [CODE_W-1:0] rr_start;
  logic [CODE_W:0]   rot_amt;
  logic [CODE_W:0]   unrot;

  assign rot_amt    = {1'b0, rr_start} + (CODE_W+1)'(1);
  assign search_vec = (elig >> rot_amt) | (elig << ((CODE_W+1)'(WIDTH) - rot_amt));
  assign unrot      = {1'b0, found_idx} + rot_amt;
  assign sel_idx    = (unrot >= (CODE_W+1)'(WIDTH)) ? CODE_W'(unrot - (CODE_W+1)'(WIDTH))
                                                    : unrot[CODE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_start <= CODE_W'(WIDTH - 1);
    end else if (flush) begin
      rr_start <= CODE_W'(WIDTH - 1);
    end else if (do_load) begin
      rr_start <= (sel_idx == '0) ? CODE_W'(WIDTH - 1) : sel_idx - CODE_W'(1);
    end
  end
`else
  assign search_vec = elig;
  assign sel_idx    = found_idx;
`endif

  // A req on the bit being loaded re-sets it after the clear (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      code_valid <= 1'b0;
      code       <= '0;
    end else if (flush) begin
      pending    <= req;
      code_valid <= 1'b0;
      code       <= '0;
    end else begin
      pending <= (pending & ~load_onehot) | req;
      if (free) begin
        code_valid <= found;
        if (found) begin
          code <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_pipe.sv
module tb_priority_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       flush;
  logic       code_valid;
  logic [2:0] code;
  logic       code_ready;
  logic [7:0] pending;
  logic       z;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  priority_encoder_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask       (mask),
    .flush      (flush),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .pending    (pending),
    .z          (z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop and compare on every sampled handshake until the scoreboard is empty.
  task automatic run_drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (code_valid && code_ready) begin
        chk("code", 32'(code), exp_q.pop_front());
      end
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] vb;
    logic [31:0] rr_second;

    rst_n = 1'b0; req = '0; mask = 8'hFF; flush = 1'b0; code_ready = 1'b1;
    #3;
    chk("rst_valid",   32'(code_valid), 32'd0);
    chk("rst_code",    32'(code),       32'd0);
    chk("rst_pending", 32'(pending),    32'd0);
    chk("rst_z",       32'(z),          32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a burst.
    req = 8'hFF; tick();
    req = 8'h00; tick();
    chk("burst_valid", 32'(code_valid), 32'd1);
    chk("burst_code",  32'(code),       32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(code_valid), 32'd0);
    chk("arst_code",    32'(code),       32'd0);
    chk("arst_pending", 32'(pending),    32'd0);
    chk("arst_z",       32'(z),          32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Mapping sweep 8'h40..8'h7F: bit 6 first, then the rest descending.
    for (int v = 'h40; v <= 'h7F; v++) begin
      do_flush();
      vb = 8'(v);
      req = vb;
      for (int b = 7; b >= 0; b--) begin
        if (vb[b]) exp_q.push_back(32'(b));
      end
      tick();
      req = '0;
      chk("sweep_pending", 32'(pending),    32'(vb));
      chk("sweep_latency", 32'(code_valid), 32'd0);
      run_drain(20, n);
      chk("sweep_empty_valid", 32'(code_valid), 32'd0);
      chk("sweep_empty_z",     32'(z),          32'd1);
    end

    // Drain order on consecutive cycles.
    do_flush();
    req = 8'b1010_0101;
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
    tick();
    req = '0;
    run_drain(20, n);
    chk("drain_cycles", 32'(n),          32'd5);
    chk("drain_valid",  32'(code_valid), 32'd0);
    chk("drain_z",      32'(z),          32'd1);

    // Backpressure holds the output stage and blocks further loads.
    code_ready = 1'b0;
    req = 8'h81; tick();
    req = 8'h00; tick();
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid",   32'(code_valid), 32'd1);
      chk("bp_code",    32'(code),       32'd7);
      chk("bp_pending", 32'(pending),    32'h01);
      chk("bp_z",       32'(z),          32'd0);
      tick();
    end
    code_ready = 1'b1;
    exp_q.push_back(7); exp_q.push_back(0);
    run_drain(20, n);
    chk("bp_done_valid", 32'(code_valid), 32'd0);

    // Masked line stays pending and is invisible to z.
    mask = 8'h7F;
    req = 8'h80; tick();
    req = 8'h00; tick(); tick();
    chk("mask_valid",   32'(code_valid), 32'd0);
    chk("mask_pending", 32'(pending),    32'h80);
    chk("mask_z",       32'(z),          32'd1);

    // Set beats clear: bit 0 re-requested on its load edge is issued twice.
    req = 8'h01; exp_q.push_back(0); tick();
    req = 8'h01; exp_q.push_back(0); tick();
    req = 8'h00;
    chk("sbc_pending", 32'(pending),    32'h81);
    chk("sbc_valid",   32'(code_valid), 32'd1);
    run_drain(20, n);
    chk("sbc_after_pending", 32'(pending),    32'h80);
    chk("sbc_after_valid",   32'(code_valid), 32'd0);
    chk("sbc_after_z",       32'(z),          32'd1);
    mask = 8'hFF;
    exp_q.push_back(7);
    run_drain(20, n);
    chk("unmask_pending", 32'(pending), 32'h00);

    // Held request 8'h88: rotation alternates, fixed priority repeats 7.
`ifdef ROUND_ROBIN_EN
    rr_second = 32'd3;
`else
    rr_second = 32'd7;
`endif
    do_flush();
    req = 8'h88;
    exp_q.push_back(7); exp_q.push_back(rr_second);
    exp_q.push_back(7); exp_q.push_back(rr_second);
    tick();
    run_drain(20, n);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_valid",   32'(code_valid), 32'd0);
    chk("flush_code",    32'(code),       32'd0);
    chk("flush_pending", 32'(pending),    32'h88);
    exp_q.push_back(7);
    run_drain(20, n);
    req = 8'h00;
    do_flush();
    chk("final_z", 32'(z), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
